// File: rtl/ux607_qspi_phy.sv
// QSPI PHY: serialises one frame byte per transfer onto SCK/DQ (single/dual/quad)
// and sequences chip-select with programmable setup and hold delays.
module ux607_qspi_phy (
    input  logic        clock,
    input  logic        reset,
    output logic        io_link_tx_ready,
    input  logic        io_link_tx_valid,
    input  logic [7:0]  io_link_tx_bits,
    output logic        io_link_rx_valid,
    output logic [7:0]  io_link_rx_bits,
    input  logic [7:0]  io_link_cnt,
    input  logic [1:0]  io_link_fmt_proto,
    input  logic        io_link_fmt_endian,
    input  logic        io_link_fmt_iodir,
    input  logic        io_link_cs_set,
    input  logic        io_link_cs_clear,
    input  logic        io_link_cs_hold,
    output logic        io_link_active,
    input  logic        io_link_lock,
    input  logic [11:0] io_ctrl_sck_div,
    input  logic        io_ctrl_sck_pol,
    input  logic        io_ctrl_sck_pha,
    input  logic [7:0]  io_ctrl_dla_cssck,
    input  logic [7:0]  io_ctrl_dla_sckcs,
    output logic        io_port_sck,
    output logic        io_port_cs,
    output logic [3:0]  io_port_dq_o,
    output logic [3:0]  io_port_dq_oe,
    input  logic [3:0]  io_port_dq_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CSSETUP = 3'd1,
        S_XFER    = 3'd2,
        S_HOLD    = 3'd3,
        S_SCKCS   = 3'd4
    } state_t;

    function automatic logic [3:0] lanes_out(input logic [7:0] sh, input logic [1:0] proto,
                                             input logic endian);
        logic [3:0] v;
        case (proto)
            2'd1:    v = endian ? {2'b00, sh[1:0]} : {2'b00, sh[7:6]};
            2'd2:    v = endian ? sh[3:0] : sh[7:4];
            default: v = endian ? {3'b000, sh[0]} : {3'b000, sh[7]};
        endcase
        return v;
    endfunction

    function automatic logic [7:0] shift_sh(input logic [7:0] sh, input logic [1:0] proto,
                                            input logic endian);
        logic [7:0] v;
        case (proto)
            2'd1:    v = endian ? {2'b00, sh[7:2]} : {sh[5:0], 2'b00};
            2'd2:    v = endian ? {4'h0, sh[7:4]} : {sh[3:0], 4'h0};
            default: v = endian ? {1'b0, sh[7:1]} : {sh[6:0], 1'b0};
        endcase
        return v;
    endfunction

    // Single protocol always listens on dq[1] (MISO) while dq[0] drives.
    function automatic logic [7:0] capture_sh(input logic [7:0] sh, input logic [3:0] dq,
                                              input logic [1:0] proto, input logic endian);
        logic [7:0] v;
        case (proto)
            2'd1:    v = endian ? {dq[1:0], sh[5:0]} : {sh[7:2], dq[1:0]};
            2'd2:    v = endian ? {dq, sh[3:0]} : {sh[7:4], dq};
            default: v = endian ? {dq[1], sh[6:0]} : {sh[7:1], dq[1]};
        endcase
        return v;
    endfunction

    function automatic logic [3:0] lanes_oe(input logic [1:0] proto, input logic iodir);
        logic [3:0] v;
        case (proto)
            2'd1:    v = iodir ? 4'b0011 : 4'b0000;
            2'd2:    v = iodir ? 4'b1111 : 4'b0000;
            default: v = 4'b0001;
        endcase
        return v;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] div_cnt_q, div_cnt_d;
    logic [8:0]  edge_q, edge_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  proto_q, proto_d;
    logic        endian_q, endian_d;
    logic        iodir_q, iodir_d;
    logic        csmode_q, csmode_d;
    logic        clr_pend_q, clr_pend_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_bits_q, rx_bits_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
    logic [3:0]  dq_o_q, dq_o_d;
    logic [3:0]  dq_oe_q, dq_oe_d;

    logic        fire_s;
    logic        release_s;
    logic        tick_s;
    logic        last_s;
    logic        cap_s;
    logic        shf_s;
    logic [8:0]  edge_n_s;
    logic [7:0]  cnt_eff_s;

    // Next-state and next-output computation for the whole PHY.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_d     = edge_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        proto_d    = proto_q;
        endian_d   = endian_q;
        iodir_d    = iodir_q;
        csmode_d   = csmode_q;
        cs_d       = cs_q;
        sck_d      = io_ctrl_sck_pol;
        rx_valid_d = 1'b0;
        rx_bits_d  = rx_bits_q;
        clr_pend_d = clr_pend_q | io_link_cs_clear;

        fire_s    = io_link_tx_valid & tx_ready_q;
        release_s = (clr_pend_q | io_link_cs_clear) & ~io_link_cs_hold;
        tick_s    = (div_cnt_q == io_ctrl_sck_div);
        edge_n_s  = edge_q + 9'd1;
        cnt_eff_s = (cnt_q == 8'd0) ? 8'd1 : cnt_q;
        last_s    = (edge_n_s == {cnt_eff_s, 1'b0});
        if (io_ctrl_sck_pha) begin
            cap_s = ~edge_n_s[0];
            shf_s = edge_n_s[0] & (edge_n_s >= 9'd3);
        end else begin
            cap_s = edge_n_s[0];
            shf_s = ~edge_n_s[0] & ~last_s;
        end

        if (fire_s) begin
            sh_d     = io_link_tx_bits;
            cnt_d    = io_link_cnt;
            proto_d  = io_link_fmt_proto;
            endian_d = io_link_fmt_endian;
            iodir_d  = io_link_fmt_iodir;
        end else begin
            sh_d = sh_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fire_s) begin
                    div_cnt_d = 12'd0;
                    edge_d    = 9'd0;
                    csmode_d  = io_link_cs_set;
                    if (io_link_cs_set) begin
                        state_d = S_CSSETUP;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = S_XFER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CSSETUP: begin
                if (div_cnt_q == {4'h0, io_ctrl_dla_cssck}) begin
                    state_d   = S_XFER;
                    div_cnt_d = 12'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 12'd1;
                end
            end
            S_XFER: begin
                sck_d = sck_q;
                if (tick_s) begin
                    div_cnt_d = 12'd0;
                    edge_d    = edge_n_s;
                    sck_d     = ~sck_q;
                    if (cap_s) begin
                        sh_d = capture_sh(sh_q, io_port_dq_i, proto_q, endian_q);
                    end else if (shf_s) begin
                        sh_d = shift_sh(sh_q, proto_q, endian_q);
                    end else begin
                        sh_d = sh_q;
                    end
                    if (last_s) begin
                        sck_d      = io_ctrl_sck_pol;
                        rx_valid_d = 1'b1;
                        rx_bits_d  = sh_d;
                        if (release_s) begin
                            state_d = S_SCKCS;
                        end else if (csmode_q) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_XFER;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 12'd1;
                end
            end
            S_HOLD: begin
                if (fire_s) begin
                    state_d   = S_XFER;
                    div_cnt_d = 12'd0;
                    edge_d    = 9'd0;
                    csmode_d  = 1'b1;
                end else if (release_s) begin
                    state_d   = S_SCKCS;
                    div_cnt_d = 12'd0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_SCKCS: begin
                if (div_cnt_q == {4'h0, io_ctrl_dla_sckcs}) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
            end
        endcase

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            clr_pend_d = 1'b0;
        end else begin
            clr_pend_d = clr_pend_d;
        end

        tx_ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
        busy_d     = (state_d != S_IDLE);
        if ((state_d == S_XFER) || (state_d == S_HOLD)) begin
            dq_o_d  = lanes_out(sh_d, proto_d, endian_d);
            dq_oe_d = lanes_oe(proto_d, iodir_d);
        end else begin
            dq_o_d  = 4'h0;
            dq_oe_d = 4'h0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= 12'd0;
            edge_q     <= 9'd0;
            sh_q       <= 8'h00;
            cnt_q      <= 8'h00;
            proto_q    <= 2'd0;
            endian_q   <= 1'b0;
            iodir_q    <= 1'b0;
            csmode_q   <= 1'b0;
            clr_pend_q <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_bits_q  <= 8'h00;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            dq_o_q     <= 4'h0;
            dq_oe_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_q     <= edge_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            proto_q    <= proto_d;
            endian_q   <= endian_d;
            iodir_q    <= iodir_d;
            csmode_q   <= csmode_d;
            clr_pend_q <= clr_pend_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            rx_valid_q <= rx_valid_d;
            rx_bits_q  <= rx_bits_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign io_link_tx_ready = tx_ready_q;
    assign io_link_rx_valid = rx_valid_q;
    assign io_link_rx_bits  = rx_bits_q;
    assign io_link_active   = busy_q | io_link_lock;
    assign io_port_sck      = sck_q;
    assign io_port_cs       = cs_q;
    assign io_port_dq_o     = dq_o_q;
    assign io_port_dq_oe    = dq_oe_q;

endmodule

// File: tb/tb_ux607_qspi_phy.sv
// Randomised bench for ux607_qspi_phy; expected receive bytes and pin timing come
// from an edge-list reference model driven by the recorded DQ input history.
module tb_ux607_qspi_phy;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_ready, tx_valid, rx_valid;
    logic [7:0]  tx_bits, rx_bits, cnt_i;
    logic [1:0]  proto_i;
    logic        endian_i, iodir_i, cs_set_i, cs_clear_i, cs_hold_i, active, lock_i;
    logic [11:0] sck_div;
    logic        sck_pol, sck_pha;
    logic [7:0]  dla_cssck, dla_sckcs;
    logic        sck, cs;
    logic [3:0]  dq_o, dq_oe, dq_i;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          dq_mode = 0;
    int          q_switch = 0;
    logic [3:0]  hist [int];

    ux607_qspi_phy dut (
        .clock(clock), .reset(reset),
        .io_link_tx_ready(tx_ready), .io_link_tx_valid(tx_valid), .io_link_tx_bits(tx_bits),
        .io_link_rx_valid(rx_valid), .io_link_rx_bits(rx_bits), .io_link_cnt(cnt_i),
        .io_link_fmt_proto(proto_i), .io_link_fmt_endian(endian_i), .io_link_fmt_iodir(iodir_i),
        .io_link_cs_set(cs_set_i), .io_link_cs_clear(cs_clear_i), .io_link_cs_hold(cs_hold_i),
        .io_link_active(active), .io_link_lock(lock_i),
        .io_ctrl_sck_div(sck_div), .io_ctrl_sck_pol(sck_pol), .io_ctrl_sck_pha(sck_pha),
        .io_ctrl_dla_cssck(dla_cssck), .io_ctrl_dla_sckcs(dla_sckcs),
        .io_port_sck(sck), .io_port_cs(cs), .io_port_dq_o(dq_o), .io_port_dq_oe(dq_oe),
        .io_port_dq_i(dq_i)
    );

    always #5 clock = ~clock;

    // Cycle index: value during a cycle names that cycle.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and drive/record the DQ inputs for that cycle.
    task automatic step();
        @(negedge clock);
        case (dq_mode)
            0:       dq_i = 4'($urandom);
            1:       dq_i = (cyc < q_switch) ? 4'h3 : 4'hC;
            default: dq_i = {2'b00, dq_o[0], 1'b0};
        endcase
        hist[cyc] = dq_i;
    endtask

    function automatic int model_rx(int data, int cnt, int proto, int endian, int pha,
                                    int e, int div, int loop);
        int l, mask, ce, sh, lane_in, out_g, dq, cap, shf;
        l    = (proto == 1) ? 2 : ((proto == 2) ? 4 : 1);
        mask = (1 << l) - 1;
        ce   = (cnt == 0) ? 1 : cnt;
        sh   = data;
        for (int n = 1; n <= 2 * ce; n++) begin
            out_g = (endian != 0) ? (sh & mask) : ((sh >> (8 - l)) & mask);
            if (loop != 0) begin
                lane_in = out_g;
            end else begin
                dq      = int'(hist[e + n * (div + 1) - 1]);
                lane_in = (l == 1) ? ((dq >> 1) & 1) : (dq & mask);
            end
            cap = (pha != 0) ? ((n % 2) == 0) : ((n % 2) == 1);
            shf = (pha != 0) ? (((n % 2) == 1) && (n >= 3)) : (((n % 2) == 0) && (n < 2 * ce));
            if (cap != 0) begin
                if (endian != 0) sh = (sh & ~(mask << (8 - l)) & 255) | (lane_in << (8 - l));
                else             sh = (sh & ~mask & 255) | lane_in;
            end else if (shf != 0) begin
                sh = (endian != 0) ? (sh >> l) : ((sh << l) & 255);
            end
        end
        return sh;
    endfunction

    function automatic int exp_oe(int proto, int iodir);
        if (proto == 1) return (iodir != 0) ? 3 : 0;
        if (proto == 2) return (iodir != 0) ? 15 : 0;
        return 1;
    endfunction

    // Fires one frame in the current cycle and checks every cycle up to rx_valid.
    task automatic run_frame(input int data, input int cnt, input int proto, input int endian,
                             input int iodir, input int cs_set, input int cs_clear,
                             input int from_hold, input int loop,
                             output int pend, output int csm);
        int t, e, r, ce, div, l, exp_sck, got_model;
        t   = cyc;
        div = int'(sck_div);
        chk("tx_ready_before_fire", tx_ready, 1);
        tx_valid = 1'b1; tx_bits = 8'(data); cnt_i = 8'(cnt); proto_i = 2'(proto);
        endian_i = 1'(endian); iodir_i = 1'(iodir); cs_set_i = 1'(cs_set);
        cs_clear_i = 1'(cs_clear);
        csm  = (from_hold != 0) ? 1 : cs_set;
        pend = cs_clear;
        ce   = (cnt == 0) ? 1 : cnt;
        e    = ((from_hold != 0) || (cs_set == 0)) ? t + 1 : t + 2 + int'(dla_cssck);
        r    = e + 2 * ce * (div + 1);
        l    = (proto == 1) ? 2 : ((proto == 2) ? 4 : 1);
        for (int c = t + 1; c <= r; c++) begin
            step();
            if (c == t + 1) begin
                tx_valid = 1'b0;
                cs_clear_i = 1'b0;
            end
            chk("cs_level", cs, (csm != 0) ? 0 : 1);
            exp_sck = (c <= e) ? int'(sck_pol) : (int'(sck_pol) ^ (((c - e) / (div + 1)) & 1));
            chk("sck_level", sck, exp_sck);
            chk("rx_valid_timing", rx_valid, (c == r) ? 1 : 0);
            if (c < r) chk("tx_ready_busy", tx_ready, 0);
            if (c == e) begin
                chk("dq_oe", dq_oe, exp_oe(proto, iodir));
                chk("dq_o_first", dq_o & ((1 << l) - 1),
                    (endian != 0) ? (data & ((1 << l) - 1)) : ((data >> (8 - l)) & ((1 << l) - 1)));
                chk("active_busy", active, 1);
            end
        end
        got_model = model_rx(data, cnt, proto, endian, int'(sck_pha), e, div, loop);
        chk("rx_bits_model", rx_bits, got_model);
        chk("tx_ready_after", tx_ready, (pend != 0) ? 0 : 1);
    endtask

    // Called in the first SCKCS cycle; checks CS release after dla_sckcs+1 cycles.
    task automatic finish_sckcs(input int csm);
        for (int i = 0; i < int'(dla_sckcs); i++) begin
            step();
            chk("cs_in_sckcs", cs, (csm != 0) ? 0 : 1);
            chk("tx_ready_sckcs", tx_ready, 0);
        end
        step();
        chk("cs_released", cs, 1);
        chk("tx_ready_idle", tx_ready, 1);
        chk("active_idle", active, 0);
    endtask

    task automatic end_hold(input int use_hold);
        cs_clear_i = 1'b1;
        cs_hold_i  = 1'(use_hold);
        step();
        cs_clear_i = 1'b0;
        if (use_hold != 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("hold_keeps_cs", cs, 0);
                chk("hold_ready", tx_ready, 1);
                step();
            end
            cs_hold_i = 1'b0;
            step();
        end
        chk("sckcs_ready", tx_ready, 0);
        chk("sckcs_cs", cs, 0);
        finish_sckcs(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend, csm, in_hold, cset, clr;
        reset = 1'b1;
        tx_valid = 1'b0; tx_bits = 8'h00; cnt_i = 8'h00; proto_i = 2'd0; endian_i = 1'b0;
        iodir_i = 1'b0; cs_set_i = 1'b0; cs_clear_i = 1'b0; cs_hold_i = 1'b0; lock_i = 1'b0;
        sck_div = 12'd0; sck_pol = 1'b0; sck_pha = 1'b0; dla_cssck = 8'd0; dla_sckcs = 8'd0;
        dq_i = 4'h0;

        step(); step();
        chk("rst_cs", cs, 1);
        chk("rst_sck", sck, 0);
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_dq_o", dq_o, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_bits", rx_bits, 0);
        chk("rst_active", active, 0);
        reset = 1'b0;
        step();
        lock_i = 1'b1;
        step();
        chk("lock_active", active, 1);
        lock_i = 1'b0;
        step();
        chk("unlock_active", active, 0);

        // Single MSB-first loopback of 0xA5, then CS release gated by cs_hold.
        dq_mode = 2;
        run_frame(32'hA5, 8, 0, 0, 1, 1, 0, 0, 1, pend, csm);
        chk("loop_rx_a5", rx_bits, 8'hA5);
        chk("loop_hold_cs", cs, 0);
        dq_mode = 0;
        dla_sckcs = 8'd2;
        end_hold(1);

        // Quad LSB-first receive with clear requested at fire.
        dla_sckcs = 8'd3;
        dq_mode = 1;
        q_switch = cyc + 4;
        run_frame(32'h5A, 2, 2, 1, 0, 1, 1, 0, 0, pend, csm);
        chk("quad_rx_c3", rx_bits, 8'hC3);
        dq_mode = 0;
        finish_sckcs(1);

        // Back-to-back frames from HOLD with div=1.
        sck_div = 12'd1; sck_pol = 1'b1; sck_pha = 1'b1; dla_cssck = 8'd2;
        step();
        run_frame(32'h3C, 3, 1, 0, 1, 1, 0, 0, 0, pend, csm);
        run_frame(32'h96, 4, 2, 0, 1, 1, 0, 1, 0, pend, csm);
        run_frame(32'h0F, 0, 0, 1, 0, 1, 1, 1, 0, pend, csm);
        finish_sckcs(1);

        // Randomised frames.
        in_hold = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_hold == 0) begin
                sck_div = 12'($urandom_range(0, 3)); sck_pol = 1'($urandom);
                sck_pha = 1'($urandom); dla_cssck = 8'($urandom_range(0, 4));
                dla_sckcs = 8'($urandom_range(0, 4));
            end
            if ((in_hold != 0) && ($urandom_range(0, 3) == 0)) begin
                end_hold(int'($urandom_range(0, 1)));
                in_hold = 0;
            end else begin
                cset = ($urandom_range(0, 3) != 0) ? 1 : 0;
                clr  = ($urandom_range(0, 4) == 0) ? 1 : 0;
                run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), cset, clr, in_hold, 0, pend, csm);
                if (pend != 0) begin
                    finish_sckcs(csm);
                    in_hold = 0;
                end else begin
                    in_hold = csm;
                end
            end
        end
        if (in_hold != 0) end_hold(0);

        // Reset asserted in the middle of a transfer.
        sck_div = 12'd2; sck_pol = 1'b0; sck_pha = 1'b0; dla_cssck = 8'd0;
        step();
        tx_valid = 1'b1; tx_bits = 8'hF0; cnt_i = 8'd8; proto_i = 2'd0; cs_set_i = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_sck", sck, 1);
        chk("pre_reset_cs", cs, 0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_cs", cs, 1);
        chk("async_rst_sck", sck, 0);
        chk("async_rst_dq_oe", dq_oe, 0);
        chk("async_rst_ready", tx_ready, 1);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("no_rx_after_reset", rx_valid, 0);
        end
        chk("idle_cs_after_reset", cs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
